// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite signal bundle between one matrix slave port and the SRAM slave.
interface ahb_lite_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave front-end for a single-port synchronous SRAM with 1-cycle read latency,
// byte/half/word access, two-cycle ERROR response and programmable read wait states.
module ahb_lite_sram_slave #(
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_lite_sram_slave_if.slave  ahb,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [3:0]            sram_be,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR       = 3'd1,
        S_RD       = 3'd2,
        S_RD_DEFER = 3'd3,
        S_ERR1     = 3'd4,
        S_ERR2     = 3'd5
    } state_e;

    localparam logic [3:0] WAIT_LIM = 4'(WAIT_STATES);

    function automatic logic size_err(input logic [2:0] size, input logic [1:0] lsb);
        size_err = (size > 3'd2) || ((size == 3'd1) && lsb[0]) || ((size == 3'd2) && (lsb != 2'd0));
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            3'd0:    lane_mask = 4'b0001 << lsb;
            3'd1:    lane_mask = lsb[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    state_e                  state_q, state_d, ap_state_s;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, haddr_word_s, addr_s;
    logic [3:0]              be_q, be_d, be_s;
    logic [3:0]              cnt_q, cnt_d;
    logic                    accept_s, err_s, rd_issue_s;
    logic                    hreadyout_s, hresp_s, cs_s, we_s;
    logic [31:0]             hrdata_s, wdata_s;
    logic                    unused_s;

    // Gating with HRESETn keeps the combinational read issue quiet while reset is held.
    assign accept_s     = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY & HRESETn;
    assign err_s        = size_err(ahb.HSIZE, ahb.HADDR[1:0]);
    assign haddr_word_s = ahb.HADDR[ADDR_WIDTH+1:2];
    assign rd_issue_s   = accept_s & ~err_s & ~ahb.HWRITE;
    assign ap_state_s   = !accept_s ? S_IDLE : (err_s ? S_ERR1 : (ahb.HWRITE ? S_WR : S_RD));
    assign unused_s     = ^{ahb.HADDR[31:ADDR_WIDTH+2], ahb.HTRANS[0]};

    // State, latched address/byte lanes and wait counter.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            be_q    <= 4'h0;
            cnt_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and bus/SRAM outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        be_d        = be_q;
        cnt_d       = cnt_q;
        hreadyout_s = 1'b1;
        hresp_s     = 1'b0;
        hrdata_s    = 32'h0;
        cs_s        = 1'b0;
        we_s        = 1'b0;
        be_s        = 4'h0;
        addr_s      = addr_q;
        wdata_s     = 32'h0;
        case (state_q)
            S_IDLE, S_ERR2: begin
                hresp_s = (state_q == S_ERR2);
                state_d = ap_state_s;
                cnt_d   = 4'h0;
                addr_d  = accept_s ? haddr_word_s : addr_q;
                be_d    = accept_s ? lane_mask(ahb.HSIZE, ahb.HADDR[1:0]) : be_q;
                cs_s    = rd_issue_s;
                addr_s  = rd_issue_s ? haddr_word_s : addr_q;
            end
            S_WR: begin
                cs_s    = 1'b1;
                we_s    = 1'b1;
                be_s    = be_q;
                wdata_s = ahb.HWDATA;
                cnt_d   = 4'h0;
                addr_d  = accept_s ? haddr_word_s : addr_q;
                be_d    = accept_s ? lane_mask(ahb.HSIZE, ahb.HADDR[1:0]) : be_q;
                // A read right behind a write must wait: the port is busy with the write now.
                if (!accept_s) begin
                    state_d = S_IDLE;
                end else if (err_s) begin
                    state_d = S_ERR1;
                end else begin
                    state_d = ahb.HWRITE ? S_WR : S_RD_DEFER;
                end
            end
            S_RD_DEFER: begin
                hreadyout_s = 1'b0;
                cs_s        = 1'b1;
                cnt_d       = 4'h0;
                state_d     = S_RD;
            end
            S_RD: begin
                hrdata_s = sram_rdata;
                if (cnt_q != WAIT_LIM) begin
                    hreadyout_s = 1'b0;
                    cs_s        = 1'b1;
                    cnt_d       = cnt_q + 4'd1;
                end else begin
                    state_d = ap_state_s;
                    cnt_d   = 4'h0;
                    addr_d  = accept_s ? haddr_word_s : addr_q;
                    be_d    = accept_s ? lane_mask(ahb.HSIZE, ahb.HADDR[1:0]) : be_q;
                    cs_s    = rd_issue_s;
                    addr_s  = rd_issue_s ? haddr_word_s : addr_q;
                end
            end
            S_ERR1: begin
                hreadyout_s = 1'b0;
                hresp_s     = 1'b1;
                state_d     = S_ERR2;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ahb.HREADYOUT = hreadyout_s;
    assign ahb.HRESP     = hresp_s;
    assign ahb.HRDATA    = hrdata_s;
    assign sram_cs       = cs_s;
    assign sram_we       = we_s;
    assign sram_be       = be_s;
    assign sram_addr     = addr_s;
    assign sram_wdata    = wdata_s;
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: directed vector tables plus random transfers against a byte-level memory model.
module tb_ahb_lite_sram_slave;
    typedef struct {
        logic        sel;
        logic        xfer;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        has_exp;
        int          exp_low;
        logic        exp_resp;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        m_sel, m_write, hold_low, use2;
    logic [1:0]  m_trans;
    logic [2:0]  m_size;
    logic [31:0] m_addr, m_wdata;

    ahb_lite_sram_slave_if b0 ();
    ahb_lite_sram_slave_if b2 ();

    logic        s0_cs, s0_we, s2_cs, s2_we;
    logic [3:0]  s0_be, s2_be;
    logic [7:0]  s0_addr, s2_addr;
    logic [31:0] s0_wdata, s2_wdata, rd0, rd2;
    logic [31:0] mem0 [256];
    logic [31:0] mem2 [256];

    assign b0.HSEL   = m_sel & ~use2;
    assign b2.HSEL   = m_sel & use2;
    assign b0.HADDR  = m_addr;   assign b2.HADDR  = m_addr;
    assign b0.HTRANS = m_trans;  assign b2.HTRANS = m_trans;
    assign b0.HWRITE = m_write;  assign b2.HWRITE = m_write;
    assign b0.HSIZE  = m_size;   assign b2.HSIZE  = m_size;
    assign b0.HWDATA = m_wdata;  assign b2.HWDATA = m_wdata;
    assign b0.HREADY = hold_low ? 1'b0 : b0.HREADYOUT;
    assign b2.HREADY = hold_low ? 1'b0 : b2.HREADYOUT;

    ahb_lite_sram_slave #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .ahb(b0.slave),
        .sram_cs(s0_cs), .sram_we(s0_we), .sram_be(s0_be), .sram_addr(s0_addr),
        .sram_wdata(s0_wdata), .sram_rdata(rd0)
    );

    ahb_lite_sram_slave #(.ADDR_WIDTH(8), .WAIT_STATES(2)) dut2 (
        .HCLK(clk), .HRESETn(rst_n), .ahb(b2.slave),
        .sram_cs(s2_cs), .sram_we(s2_we), .sram_be(s2_be), .sram_addr(s2_addr),
        .sram_wdata(s2_wdata), .sram_rdata(rd2)
    );

    // SRAM behind dut0
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem0[i] <= 32'h0;
            rd0 <= 32'h0;
        end else if (s0_cs) begin
            if (s0_we) begin
                for (int k = 0; k < 4; k++) if (s0_be[k]) mem0[s0_addr][8*k +: 8] <= s0_wdata[8*k +: 8];
            end else begin
                rd0 <= mem0[s0_addr];
            end
        end
    end

    // SRAM behind dut2
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem2[i] <= 32'h0;
            rd2 <= 32'h0;
        end else if (s2_cs) begin
            if (s2_we) begin
                for (int k = 0; k < 4; k++) if (s2_be[k]) mem2[s2_addr][8*k +: 8] <= s2_wdata[8*k +: 8];
            end else begin
                rd2 <= mem2[s2_addr];
            end
        end
    end

    logic        o_ready, o_resp, o_cs, o_we;
    logic [31:0] o_hrdata;
    logic [3:0]  o_be;
    logic [7:0]  o_addr;
    assign o_ready  = use2 ? b2.HREADYOUT : b0.HREADYOUT;
    assign o_resp   = use2 ? b2.HRESP     : b0.HRESP;
    assign o_hrdata = use2 ? b2.HRDATA    : b0.HRDATA;
    assign o_cs     = use2 ? s2_cs : s0_cs;
    assign o_we     = use2 ? s2_we : s0_we;
    assign o_be     = use2 ? s2_be : s0_be;
    assign o_addr   = use2 ? s2_addr : s0_addr;

    // Reference memory: byte array, 1 KiB per instance (8 word-address bits), addresses wrap.
    logic [7:0] mdl0 [1024];
    logic [7:0] mdl2 [1024];
    vec_t vq[$];
    vec_t dir0[$];
    vec_t dir2[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_err(input logic [2:0] size, input logic [31:0] a);
        int n;
        n = 1 << size;
        return (n > 4) || ((int'(a[1:0]) % n) != 0);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] size, input logic [31:0] a);
        logic [3:0] be;
        be = 4'h0;
        for (int k = 0; k < (1 << size); k++) be[a[1:0] + 2'(k)] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] mdl_read(input logic inst2, input logic [31:0] a);
        logic [31:0] r;
        logic [9:0]  b;
        r = 32'h0;
        for (int k = 0; k < 4; k++) begin
            b = {a[9:2], 2'(k)};
            r[8*k +: 8] = inst2 ? mdl2[b] : mdl0[b];
        end
        return r;
    endfunction

    task automatic mdl_write(input logic inst2, input vec_t v);
        logic [9:0] b;
        for (int k = 0; k < (1 << v.size); k++) begin
            b = v.addr[9:0] + 10'(k);
            if (inst2) mdl2[b] = v.wdata[{b[1:0], 3'b000} +: 8];
            else       mdl0[b] = v.wdata[{b[1:0], 3'b000} +: 8];
        end
    endtask

    function automatic vec_t V(input logic wr, input logic [2:0] size, input logic [31:0] a,
                               input logic [31:0] d, input int lo, input logic rs,
                               input logic [31:0] rdv, input logic [3:0] be);
        vec_t v;
        v.sel = 1'b1; v.xfer = 1'b1; v.wr = wr; v.size = size; v.addr = a; v.wdata = d;
        v.has_exp = 1'b1; v.exp_low = lo; v.exp_resp = rs; v.exp_rdata = rdv; v.exp_be = be;
        return v;
    endfunction

    function automatic vec_t I();
        vec_t v;
        v = V(1'b0, 3'd0, 32'h0, 32'h0, 0, 1'b0, 32'h0, 4'h0);
        v.xfer = 1'b0; v.has_exp = 1'b0;
        return v;
    endfunction

    // Pipelined AHB master: drains vq, checks each data phase when it completes.
    task automatic run(input logic inst2, input int ws);
        vec_t ap, dp;
        logic have_ap, have_dp, dp_err, acc, prev_wr;
        int low, dp_low, guard;
        use2 = inst2; have_dp = 1'b0; dp_err = 1'b0; low = 0; dp_low = 0; guard = 0;
        dp = I();
        have_ap = (vq.size() > 0);
        ap = have_ap ? vq.pop_front() : I();
        while ((have_ap || have_dp) && guard < 4000) begin
            guard++;
            m_sel   = have_ap & ap.sel;
            m_trans = (have_ap & ap.xfer) ? 2'b10 : 2'b00;
            m_write = ap.wr; m_size = ap.size; m_addr = ap.addr;
            m_wdata = (have_dp && dp.wr) ? dp.wdata : 32'h0;
            @(negedge clk);
            if (have_dp && !o_ready) begin
                low++;
                chk("wait_resp", 32'(o_resp), 32'(dp_err));
                if (dp_err) chk("err_no_sram", 32'(o_cs), 32'h0);
                if (low > 20) begin
                    chk("wait_bound", 32'(low), 32'(dp_low));
                    have_dp = 1'b0; have_ap = 1'b0; vq.delete();
                end
            end else if (have_dp) begin
                chk("wait_cycles", 32'(low), 32'(dp_low));
                chk("resp", 32'(o_resp), 32'(dp.has_exp ? dp.exp_resp : dp_err));
                if (!dp_err && dp.wr) begin
                    chk("wr_cs_we", 32'({o_cs, o_we}), 32'h3);
                    chk("wr_be", 32'(o_be), 32'(dp.has_exp ? dp.exp_be : model_be(dp.size, dp.addr)));
                    chk("wr_addr", 32'(o_addr), 32'(dp.addr[9:2]));
                    chk("wr_hrdata", o_hrdata, 32'h0);
                    mdl_write(inst2, dp);
                end else if (!dp_err) begin
                    chk("rd_data", o_hrdata, dp.has_exp ? dp.exp_rdata : mdl_read(inst2, dp.addr));
                end else begin
                    chk("err_hrdata", o_hrdata, 32'h0);
                end
            end else begin
                chk("idle_ready", 32'(o_ready), 32'h1);
                chk("idle_resp", 32'(o_resp), 32'h0);
            end
            if (o_ready) begin
                acc     = have_ap & ap.sel & ap.xfer;
                prev_wr = have_dp & dp.wr & ~dp_err;
                if (acc) begin
                    dp     = ap;
                    dp_err = is_err(ap.size, ap.addr);
                    dp_low = dp_err ? 1 : (ap.wr ? 0 : ws + (prev_wr ? 1 : 0));
                    if (ap.has_exp) dp_low = ap.exp_low;
                end
                have_dp = acc; low = 0;
                have_ap = (vq.size() > 0);
                ap = have_ap ? vq.pop_front() : I();
            end
            @(posedge clk); #1;
        end
        chk("run_bounded", 32'(guard < 4000), 32'h1);
        m_sel = 1'b0; m_trans = 2'b00; m_wdata = 32'h0;
    endtask

    task automatic add_random(input int n);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            logic [1:0] lsb;
            v = I();
            v.sel  = ($urandom_range(0, 9) != 0);
            v.xfer = ($urandom_range(0, 6) != 0);
            v.wr   = 1'($urandom_range(0, 1));
            v.size = ($urandom_range(0, 9) == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
            lsb = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) lsb = (v.size == 3'd1) ? {lsb[1], 1'b0} : ((v.size == 3'd2) ? 2'b00 : lsb);
            v.addr  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'(lsb);
            v.wdata = $urandom;
            vq.push_back(v);
        end
    endtask

    initial begin
        foreach (mdl0[i]) mdl0[i] = 8'h0;
        foreach (mdl2[i]) mdl2[i] = 8'h0;
        rst_n = 1'b0; hold_low = 1'b0; use2 = 1'b0;
        m_sel = 1'b0; m_trans = 2'b00; m_write = 1'b0; m_size = 3'd0; m_addr = 32'h0; m_wdata = 32'h0;

        dir0.push_back(V(1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 0, 1'b0, 32'h0,        4'hF));
        dir0.push_back(I());
        dir0.push_back(V(1'b0, 3'd2, 32'h10,  32'h0,        0, 1'b0, 32'hDEADBEEF, 4'h0));
        dir0.push_back(V(1'b1, 3'd0, 32'h33,  32'hA500_0000, 0, 1'b0, 32'h0,       4'h8));
        dir0.push_back(I());
        dir0.push_back(V(1'b0, 3'd2, 32'h30,  32'h0,        0, 1'b0, 32'hA500_0000, 4'h0));
        dir0.push_back(V(1'b1, 3'd2, 32'h20,  32'h1234_5678, 0, 1'b0, 32'h0,       4'hF));
        dir0.push_back(V(1'b0, 3'd2, 32'h20,  32'h0,        1, 1'b0, 32'h1234_5678, 4'h0));
        dir0.push_back(V(1'b0, 3'd1, 32'h01,  32'h0,        1, 1'b1, 32'h0,        4'h0));
        dir0.push_back(V(1'b0, 3'd3, 32'h40,  32'h0,        1, 1'b1, 32'h0,        4'h0));
        dir0.push_back(V(1'b0, 3'd2, 32'h10,  32'h0,        0, 1'b0, 32'hDEADBEEF, 4'h0));
        dir0.push_back(V(1'b1, 3'd1, 32'h22,  32'hBEEF_0000, 0, 1'b0, 32'h0,       4'hC));
        dir0.push_back(V(1'b0, 3'd2, 32'h20,  32'h0,        1, 1'b0, 32'hBEEF_5678, 4'h0));
        dir0.push_back(V(1'b1, 3'd2, 32'h42,  32'h0,        1, 1'b1, 32'h0,        4'h0));
        dir0.push_back(I());
        dir0.push_back(V(1'b0, 3'd2, 32'h410, 32'h0,        0, 1'b0, 32'hDEADBEEF, 4'h0));

        dir2.push_back(V(1'b1, 3'd2, 32'h0,   32'h1111_1111, 0, 1'b0, 32'h0,       4'hF));
        dir2.push_back(V(1'b1, 3'd2, 32'h4,   32'h2222_2222, 0, 1'b0, 32'h0,       4'hF));
        dir2.push_back(V(1'b1, 3'd2, 32'h8,   32'h3333_3333, 0, 1'b0, 32'h0,       4'hF));
        dir2.push_back(V(1'b1, 3'd2, 32'hC,   32'h4444_4444, 0, 1'b0, 32'h0,       4'hF));
        dir2.push_back(V(1'b0, 3'd2, 32'h0,   32'h0,        3, 1'b0, 32'h1111_1111, 4'h0));
        dir2.push_back(V(1'b0, 3'd2, 32'h4,   32'h0,        2, 1'b0, 32'h2222_2222, 4'h0));
        dir2.push_back(V(1'b0, 3'd2, 32'h8,   32'h0,        2, 1'b0, 32'h3333_3333, 4'h0));
        dir2.push_back(V(1'b0, 3'd2, 32'hC,   32'h0,        2, 1'b0, 32'h4444_4444, 4'h0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'h1);
        chk("rst_resp", 32'(o_resp), 32'h0);
        chk("rst_hrdata", o_hrdata, 32'h0);
        chk("rst_cs_we_be", 32'({o_cs, o_we, o_be}), 32'h0);
        chk("rst_addr", 32'(o_addr), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < dir0.size(); i++) vq.push_back(dir0[i]);
        run(1'b0, 0);

        // Selected NONSEQ read with HREADY held low must be ignored.
        use2 = 1'b0; hold_low = 1'b1;
        m_sel = 1'b1; m_trans = 2'b10; m_write = 1'b0; m_size = 3'd2; m_addr = 32'h10;
        @(negedge clk);
        chk("noacc_cs", 32'(o_cs), 32'h0);
        @(posedge clk); #1;
        hold_low = 1'b0; m_sel = 1'b0; m_trans = 2'b00;
        @(negedge clk);
        chk("noacc_ready", 32'(o_ready), 32'h1);
        chk("noacc_hrdata", o_hrdata, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < dir2.size(); i++) vq.push_back(dir2[i]);
        run(1'b1, 2);

        add_random(200);
        run(1'b0, 0);
        add_random(200);
        run(1'b1, 2);

        // Reset asserted while dut2 is holding a read in wait states.
        use2 = 1'b1;
        m_sel = 1'b1; m_trans = 2'b10; m_write = 1'b0; m_size = 3'd2; m_addr = 32'h8;
        @(posedge clk); #1;
        m_sel = 1'b0; m_trans = 2'b00;
        @(negedge clk);
        chk("rdwait_ready", 32'(o_ready), 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(o_ready), 32'h1);
        chk("midrst_resp", 32'(o_resp), 32'h0);
        chk("midrst_hrdata", o_hrdata, 32'h0);
        chk("midrst_cs_we_be", 32'({o_cs, o_we, o_be}), 32'h0);
        chk("midrst_addr", 32'(o_addr), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
